tribus_xmit: RTL and testbench



---
 rtl/tribus_pkg.sv | 45 ++++
 rtl/tribus_rr_arb.sv | 36 +++
 rtl/tribus_xmit.sv | 153 +++++++++++++++
 tb/tb_tribus_xmit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared definitions for the tri-state bus transmitter: FSM state encoding,
// sizing constants and the round-robin selection helper.
package tribus_pkg;

    // Upper bound on requesters; the picker always works on this many lanes.
    localparam int MAX_CLIENT = 8;
    // Width of client indices and the round-robin pointer.
    localparam int PTR_W      = 3;
    // Width of the shared hold/turnaround counter (HOLD goes up to 15).
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // Scan n requesters starting at ptr and wrapping; return the first active one.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CLIENT-1:0] req,
        input logic [PTR_W-1:0]      ptr,
        input int unsigned           n
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        if (n != 0) begin
            for (int unsigned k = 0; k < MAX_CLIENT; k++) begin
                cand = (32'(ptr) + k) % n;
                if ((k < n) && !res.valid && req[cand[PTR_W-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = cand[PTR_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tribus_rr_arb.sv
// Combinational round-robin picker: highest priority goes to the client at
// ptr, then ptr+1, ... wrapping at NCLIENT. Produces one-hot and binary forms.
module tribus_rr_arb
    import tribus_pkg::*;
#(
    parameter int NCLIENT = 4
) (
    input  logic [NCLIENT-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx,
    output logic [NCLIENT-1:0] onehot
);

    logic [MAX_CLIENT-1:0] req_ext;
    rr_pick_t              pick;

    // Zero-extend the request vector to the fixed picker width.
    for (genvar gi = 0; gi < MAX_CLIENT; gi++) begin : g_req_ext
        if (gi < NCLIENT) begin : g_used
            assign req_ext[gi] = req[gi];
        end else begin : g_unused
            assign req_ext[gi] = 1'b0;
        end
    end

    assign pick  = rr_pick(req_ext, ptr, NCLIENT);
    assign valid = pick.valid;
    assign idx   = pick.idx;

    // Decode the winner index into a one-hot grant vector.
    for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_onehot
        assign onehot[gi] = pick.valid && (pick.idx == PTR_W'(gi));
    end

endmodule

// File: rtl/tribus_xmit.sv
// Transmit-side controller for a shared tri-state bus. Arbitrates among the
// requesters, drives the winner's latched word for HOLD cycles, then releases
// the bus for TURN cycles before the next arbitration.
// Optional build macro: TRIBUS_READBACK_EN -- adds a resolved-bus readback
// comparator with a sticky err flag; without it err is constant 0.
module tribus_xmit
    import tribus_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int W       = 8,
    parameter int HOLD    = 2,
    parameter int TURN    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCLIENT-1:0]   req,
    input  logic [NCLIENT*W-1:0] data_in,
    output logic [NCLIENT-1:0]   gnt,
    output logic [NCLIENT-1:0]   done,
    inout  wire  [W-1:0]         bus,
    output logic                 bus_oe,
    output logic                 busy,
    output logic                 err
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_idx_q, owner_idx_d;
    logic [NCLIENT-1:0]  owner_oh_q, owner_oh_d;
    logic [W-1:0]        data_q, data_d;

    logic                arb_valid;
    logic [PTR_W-1:0]    arb_idx;
    logic [NCLIENT-1:0]  arb_oh;
    logic [W-1:0]        sel_word;

    tribus_rr_arb #(
        .NCLIENT (NCLIENT)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr_q),
        .valid  (arb_valid),
        .idx    (arb_idx),
        .onehot (arb_oh)
    );

    // Pick the current owner's word out of the flattened client data bus.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NCLIENT; k++) begin
            if (owner_oh_q[k]) begin
                sel_word = sel_word | data_in[k*W +: W];
            end
        end
    end

    // State, counter, pointer, owner and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            owner_idx_q <= '0;
            owner_oh_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_idx_q <= owner_idx_d;
            owner_oh_q  <= owner_oh_d;
            data_q      <= data_d;
        end
    end

    // Next-state logic and outputs; outputs depend on registers only, so they
    // can change only at clock edges.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_idx_d = owner_idx_q;
        owner_oh_d  = owner_oh_q;
        data_d      = data_q;
        gnt         = '0;
        done        = '0;
        bus_oe      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_idx_d = arb_idx;
                    owner_oh_d  = arb_oh;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The word is captured here; later data_in changes are ignored.
                gnt     = owner_oh_q;
                data_d  = sel_word;
                cnt_d   = '0;
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                gnt    = owner_oh_q;
                bus_oe = 1'b1;
                if (cnt_q == CNT_W'(HOLD - 1)) begin
                    done     = owner_oh_q;
                    cnt_d    = '0;
                    state_d  = ST_TURN;
                    rr_ptr_d = (owner_idx_q == PTR_W'(NCLIENT - 1)) ? '0
                                                                    : owner_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == CNT_W'(TURN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign bus  = bus_oe ? data_q : {W{1'bz}};

`ifdef TRIBUS_READBACK_EN
    logic err_q;

    // Sticky readback check from the second drive cycle on, once the bus has
    // settled; x or z on any bit counts as a mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_DRIVE) && (cnt_q != '0) && (bus !== data_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tribus_xmit.sv
// Scoreboard bench for tribus_xmit: stimulus pushes expected transfers,
// a negedge monitor pops and checks them when done pulses.
// Honors TRIBUS_READBACK_EN for the readback collision case.
module tb_tribus_xmit;

    localparam int NCLIENT = 4;
    localparam int W       = 8;
    localparam int HOLD    = 2;
    localparam int TURN    = 1;

    logic                 clk;
    logic                 reset;
    logic [NCLIENT-1:0]   req;
    logic [NCLIENT*W-1:0] data_in;
    logic [NCLIENT-1:0]   gnt;
    logic [NCLIENT-1:0]   done;
    wire  [W-1:0]         bus;
    logic                 bus_oe;
    logic                 busy;
    logic                 err;

`ifdef TRIBUS_READBACK_EN
    logic drv_en = 1'b0;
    assign bus[0] = drv_en ? 1'b1 : 1'bz;
`endif

    tribus_xmit #(
        .NCLIENT (NCLIENT),
        .W       (W),
        .HOLD    (HOLD),
        .TURN    (TURN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .done    (done),
        .bus     (bus),
        .bus_oe  (bus_oe),
        .busy    (busy),
        .err     (err)
    );

    typedef struct {
        int         client;
        logic [7:0] word;
        int         start;    // cycle req was raised from idle, or -1
        int         gap;      // required cycles since previous done, or 0
        bit         chk_bus;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int client, input logic [7:0] word, input int start,
                        input int gap, input bit chk_bus);
        item_t it;
        it.client  = client;
        it.word    = word;
        it.start   = start;
        it.gap     = gap;
        it.chk_bus = chk_bus;
        sb.push_back(it);
    endtask

    task automatic set_word(input int client, input logic [7:0] word);
        data_in[client*W +: W] = word;
    endtask

    task automatic wait_oe(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_oe && n < 50);
        chk({tag, "_oe_seen"}, 32'(bus_oe), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int client);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[client] && n < 50);
        chk({tag, "_done_seen"}, 32'(done[client]), 32'd1);
    endtask

    // Monitor: check every driven cycle against the scoreboard head, retire on done.
    int win_len    = 0;
    int since_done = 99;
    int last_done  = -1000;
    always @(negedge clk) begin
        item_t cur;
        if (reset) begin
            win_len    = 0;
            since_done = 99;
        end else begin
            if (bus_oe) begin
                win_len++;
                if (sb.size() == 0) begin
                    chk("unexpected_drive", 32'(sb.size()), 32'd1);
                end else begin
                    cur = sb[0];
                    chk("gnt_owner", 32'(gnt), 32'd1 << cur.client);
                    if (cur.chk_bus) chk("bus_word", 32'(bus), 32'(cur.word));
                end
            end else if (done == '0) begin
                win_len = 0;
            end
            if (since_done >= 1 && since_done <= TURN) begin
                chk("turn_oe", 32'(bus_oe), 32'd0);
                chk("turn_gnt", 32'(gnt), 32'd0);
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    $display("xfer client=%0d word=%02h cyc=%0d", cur.client, cur.word, cyc);
                    chk("done_owner", 32'(done), 32'd1 << cur.client);
                    chk("hold_len", 32'(win_len), 32'(HOLD));
                    if (cur.start >= 0) chk("latency", 32'(cyc), 32'(cur.start + 1 + HOLD));
                    if (cur.gap > 0)    chk("spacing", 32'(cyc - last_done), 32'(cur.gap));
                end
                last_done  = cyc;
                since_done = 0;
            end
            if (since_done < 99) since_done++;
`ifndef TRIBUS_READBACK_EN
            chk("err_tied", 32'(err), 32'd0);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oe", 32'(bus_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        data_in = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oe", 32'(bus_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Single transfer from client 1.
        @(negedge clk);
        set_word(1, 8'hA5);
        push(1, 8'hA5, cyc, 0, 1'b1);
        req = 4'b0010;
        @(negedge clk);
        chk("t1_gnt_grant", 32'(gnt), 32'h2);
        chk("t1_oe_grant", 32'(bus_oe), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 1);
        req = '0;
        @(negedge clk);
        chk("t1_released", 32'(bus_oe), 32'd0);

        // Round-robin fairness with all requests held, from a fresh pointer.
        do_reset();
        for (int i = 0; i < NCLIENT; i++) set_word(i, 8'(8'h10 + i));
        for (int k = 0; k < 8; k++) begin
            push(k % NCLIENT, 8'(8'h10 + (k % NCLIENT)), (k == 0) ? cyc : -1,
                 (k == 0) ? 0 : (2 + HOLD + TURN), 1'b1);
        end
        req = 4'b1111;
        begin
            int seen = 0;
            int n    = 0;
            while (seen < 8 && n < 60) begin
                @(negedge clk);
                n++;
                if (done != '0) seen++;
            end
            chk("rr_all_done", 32'(seen), 32'd8);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Request dropped during drive: window still completes.
        set_word(2, 8'h3C);
        push(2, 8'h3C, cyc, 0, 1'b1);
        req = 4'b0100;
        wait_oe("drop");
        req = '0;
        wait_done("drop", 2);
        repeat (2) @(negedge clk);
        chk("drop_idle", 32'(busy), 32'd0);

        // Reset in the first drive cycle, then re-arbitrate from pointer 0.
        set_word(0, 8'h55);
        push(0, 8'h55, cyc, 0, 1'b1);
        req = 4'b0001;
        wait_oe("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_oe", 32'(bus_oe), 32'd0);
        chk("rstmid_gnt", 32'(gnt), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        sb.delete();
        reset = 1'b0;
        set_word(0, 8'h77);
        set_word(3, 8'h99);
        push(0, 8'h77, cyc, 0, 1'b1);
        push(3, 8'h99, -1, 2 + HOLD + TURN, 1'b1);
        req = 4'b1001;
        @(negedge clk);
        chk("rstmid_regrant", 32'(gnt), 32'h1);
        wait_done("rstmid0", 0);
        req = 4'b1000;
        wait_done("rstmid3", 3);
        req = '0;
        repeat (3) @(negedge clk);

        // Data latch isolation: word3 changes mid-drive.
        set_word(3, 8'h11);
        push(3, 8'h11, cyc, 0, 1'b1);
        req = 4'b1000;
        wait_oe("latch");
        set_word(3, 8'hEE);
        wait_done("latch", 3);
        req = '0;
        repeat (3) @(negedge clk);

        // Readback: collide on bit 0 when the feature is built, else plain transfer.
        set_word(0, 8'h00);
`ifdef TRIBUS_READBACK_EN
        push(0, 8'h00, cyc, 0, 1'b0);
        req = 4'b0001;
        wait_oe("rb");
        drv_en = 1'b1;
        wait_done("rb", 0);
        drv_en = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rb_err_set", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("rb_err_sticky", 32'(err), 32'd1);
`else
        push(0, 8'h00, cyc, 0, 1'b1);
        req = 4'b0001;
        wait_done("rb", 0);
        req = '0;
        @(negedge clk);
        chk("rb_err_off", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
`endif
        do_reset();
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
